// File: rtl/mem_access_if.sv
// Instruction and data memory channels between the sequencer (master) and the memory system (slave).
// A transfer on any channel happens on the rising clk edge where its valid and ready are both 1.
// The sender holds valid and payload stable until that edge. The receiver may drive ready freely.
interface mem_access_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int MASK_W = DATA_W / 8
);
  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [ADDR_W-1:0] imem_req_addr;
  logic              imem_rsp_valid;
  logic              imem_rsp_ready;
  logic [DATA_W-1:0] imem_rsp_data;

  logic              dmem_r_valid;
  logic              dmem_r_ready;
  logic [ADDR_W-1:0] dmem_r_addr;
  logic              dmem_rr_valid;
  logic              dmem_rr_ready;
  logic [DATA_W-1:0] dmem_rr_data;

  logic              dmem_w_valid;
  logic              dmem_w_ready;
  logic [ADDR_W-1:0] dmem_w_addr;
  logic [DATA_W-1:0] dmem_w_data;
  logic [MASK_W-1:0] dmem_w_mask;
  logic              dmem_wr_valid;
  logic              dmem_wr_ready;

  modport master (
    output imem_req_valid, imem_req_addr, imem_rsp_ready,
    output dmem_r_valid, dmem_r_addr, dmem_rr_ready,
    output dmem_w_valid, dmem_w_addr, dmem_w_data, dmem_w_mask, dmem_wr_ready,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  dmem_r_ready, dmem_rr_valid, dmem_rr_data,
    input  dmem_w_ready, dmem_wr_valid
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, imem_rsp_ready,
    input  dmem_r_valid, dmem_r_addr, dmem_rr_ready,
    input  dmem_w_valid, dmem_w_addr, dmem_w_data, dmem_w_mask, dmem_wr_ready,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output dmem_r_ready, dmem_rr_valid, dmem_rr_data,
    output dmem_w_ready, dmem_wr_valid
  );
endinterface

// File: rtl/mem_access_fsm.sv
// Multi-cycle memory sequencer: fetch (with a one-word instruction buffer), optional data read,
// then optional data write, holding stall until the instruction's memory work is done.
module mem_access_fsm #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int MASK_W  = DATA_W / 8,
  parameter int IBUF_EN = 1,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  input  logic              re_mem,
  input  logic              we_mem,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [MASK_W-1:0] wmask,
  input  logic              fence_i,
  mem_access_if.master      mem,
  output logic [DATA_W-1:0] inst_word,
  output logic [DATA_W-1:0] rdata,
  output logic              stall,
  output logic              bus_err,
  output logic [2:0]        dbg_state
);
  typedef enum logic [2:0] {
    CHK, IF_REQ, IF_WAIT, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, DONE
  } state_e;

  localparam int TAG_W = ADDR_W - 3;
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);
  localparam bit TO_EN = (TIMEOUT != 0);
  localparam bit BUF_EN = (IBUF_EN != 0);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic              buf_vld_q, buf_vld_d;
  logic [DATA_W-1:0] inst_q, inst_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              bus_err_q, bus_err_d;

  logic in_phase;
  logic timeout_hit;
  logic ibuf_hit;
  logic unused_pc_bits;

  assign in_phase    = (state_q inside {IF_REQ, IF_WAIT, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT});
  assign timeout_hit = TO_EN && in_phase && (cnt_q == TO_VAL);
  assign ibuf_hit    = BUF_EN && buf_vld_q && !fence_i && (pc[ADDR_W-1:3] == tag_q);
  assign unused_pc_bits = ^pc[2:0];

  // Data phases run read first, then write, so a combined access sees old memory contents.
  function automatic state_e data_next(input logic re, input logic we);
    if (re)      return RD_REQ;
    else if (we) return WR_REQ;
    else         return DONE;
  endfunction

  always_comb begin
    state_d   = state_q;
    tag_d     = tag_q;
    buf_vld_d = buf_vld_q;
    inst_d    = inst_q;
    rdata_d   = rdata_q;
    bus_err_d = bus_err_q;
    if (timeout_hit) begin
      state_d   = DONE;
      bus_err_d = 1'b1;
      if (state_q == IF_REQ || state_q == IF_WAIT) inst_d  = '0;
      if (state_q == RD_REQ || state_q == RD_WAIT) rdata_d = '0;
    end else begin
      case (state_q)
        CHK: begin
          if (fence_i) buf_vld_d = 1'b0;
          state_d = ibuf_hit ? data_next(re_mem, we_mem) : IF_REQ;
        end
        IF_REQ:  if (mem.imem_req_ready) state_d = IF_WAIT;
        IF_WAIT: if (mem.imem_rsp_valid) begin
          inst_d    = mem.imem_rsp_data;
          tag_d     = pc[ADDR_W-1:3];
          buf_vld_d = 1'b1;
          state_d   = data_next(re_mem, we_mem);
        end
        RD_REQ:  if (mem.dmem_r_ready) state_d = RD_WAIT;
        RD_WAIT: if (mem.dmem_rr_valid) begin
          rdata_d = mem.dmem_rr_data;
          state_d = we_mem ? WR_REQ : DONE;
        end
        WR_REQ:  if (mem.dmem_w_ready) begin
          // A store into the buffered word makes the buffered copy stale.
          if (mem_addr[ADDR_W-1:3] == tag_q) buf_vld_d = 1'b0;
          state_d = WR_WAIT;
        end
        WR_WAIT: if (mem.dmem_wr_valid) state_d = DONE;
        DONE:    state_d = CHK;
        default: state_d = CHK;
      endcase
    end
    cnt_d = (state_d != state_q || !in_phase) ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CHK;
      cnt_q     <= '0;
      tag_q     <= '0;
      buf_vld_q <= 1'b0;
      inst_q    <= '0;
      rdata_q   <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tag_q     <= tag_d;
      buf_vld_q <= buf_vld_d;
      inst_q    <= inst_d;
      rdata_q   <= rdata_d;
      bus_err_q <= bus_err_d;
    end
  end

  // The abort cycle withdraws valid/ready so no transfer can slip through as the phase is dropped.
  assign mem.imem_req_valid = !rst && !timeout_hit && (state_q == IF_REQ);
  assign mem.imem_rsp_ready = !rst && !timeout_hit && (state_q == IF_WAIT);
  assign mem.dmem_r_valid   = !rst && !timeout_hit && (state_q == RD_REQ);
  assign mem.dmem_rr_ready  = !rst && !timeout_hit && (state_q == RD_WAIT);
  assign mem.dmem_w_valid   = !rst && !timeout_hit && (state_q == WR_REQ);
  assign mem.dmem_wr_ready  = !rst && !timeout_hit && (state_q == WR_WAIT);

  assign mem.imem_req_addr = {pc[ADDR_W-1:3], 3'b000};
  assign mem.dmem_r_addr   = mem_addr;
  assign mem.dmem_w_addr   = mem_addr;
  assign mem.dmem_w_data   = wdata;
  assign mem.dmem_w_mask   = wmask;

  assign inst_word = inst_q;
  assign rdata     = rdata_q;
  assign bus_err   = bus_err_q;
  assign stall     = rst || (state_q != DONE);
  assign dbg_state = state_q;
endmodule

// File: tb/tb_mem_access_fsm.sv
// Directed bench for mem_access_fsm: behavioural memory responders plus hand-computed latencies,
// buffer hit/miss, timeout abort and mid-transaction reset behaviour.
module tb_mem_access_fsm;
  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;
  localparam int MASK_W = 8;

  localparam logic [63:0] W0 = 64'h1111_2222_3333_4444;
  localparam logic [63:0] W1 = 64'h5555_6666_7777_8888;
  localparam logic [63:0] W2 = 64'h9999_AAAA_BBBB_CCCC;
  localparam logic [63:0] R1 = 64'hDEAD_BEEF_CAFE_F00D;
  localparam logic [63:0] R2 = 64'h0123_4567_89AB_CDEF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [ADDR_W-1:0] pc = '0;
  logic re_mem = 1'b0, we_mem = 1'b0, fence_i = 1'b0;
  logic [ADDR_W-1:0] mem_addr = '0;
  logic [DATA_W-1:0] wdata = '0;
  logic [MASK_W-1:0] wmask = '0;
  logic [DATA_W-1:0] inst_word, rdata;
  logic stall, bus_err;
  logic [2:0] dbg_state;

  mem_access_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W)) mif ();

  mem_access_fsm #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W), .IBUF_EN(1), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .pc(pc), .re_mem(re_mem), .we_mem(we_mem), .mem_addr(mem_addr),
    .wdata(wdata), .wmask(wmask), .fence_i(fence_i), .mem(mif),
    .inst_word(inst_word), .rdata(rdata), .stall(stall), .bus_err(bus_err), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // responder configuration and observation counters
  int i_delay = 0, r_delay = 0, w_delay = 0;
  logic [63:0] i_data = '0, r_data = '0;
  logic r_hold = 1'b0;
  logic [63:0] r_exp_addr = '0;
  int i_req_cnt = 0, i_vcyc = 0, r_req_cnt = 0, r_rsp_cnt = 0, r_bad_addr = 0, w_req_cnt = 0;
  logic [63:0] i_last_addr = '0, w_last_addr = '0, w_last_data = '0;
  logic [7:0] w_last_mask = '0;
  logic w_seen = 1'b0;
  int w_first_rrsp = -1;

  // instruction memory responder: all decisions made just after the falling edge
  initial begin : imem_resp
    int wcnt;
    logic req_fire, rsp_fire;
    wcnt = 0; req_fire = 0; rsp_fire = 0;
    mif.imem_req_ready = 0; mif.imem_rsp_valid = 0; mif.imem_rsp_data = '0;
    forever begin
      @(negedge clk); #1;
      if (rst) begin
        mif.imem_req_ready = 0; mif.imem_rsp_valid = 0; req_fire = 0; rsp_fire = 0; wcnt = 0;
      end else begin
        if (rsp_fire) mif.imem_rsp_valid = 0;
        if (req_fire) begin mif.imem_rsp_valid = 1; mif.imem_rsp_data = i_data; end
        if (mif.imem_req_valid) begin
          i_vcyc++;
          i_last_addr = mif.imem_req_addr;
          mif.imem_req_ready = (wcnt >= i_delay);
          wcnt++;
        end else begin
          mif.imem_req_ready = 0; wcnt = 0;
        end
        req_fire = mif.imem_req_valid && mif.imem_req_ready;
        if (req_fire) begin i_req_cnt++; wcnt = 0; end
        rsp_fire = mif.imem_rsp_valid && mif.imem_rsp_ready;
      end
    end
  end

  // data read responder
  initial begin : dmem_r_resp
    int wcnt;
    logic req_fire, rsp_fire;
    wcnt = 0; req_fire = 0; rsp_fire = 0;
    mif.dmem_r_ready = 0; mif.dmem_rr_valid = 0; mif.dmem_rr_data = '0;
    forever begin
      @(negedge clk); #1;
      if (rst) begin
        mif.dmem_r_ready = 0; mif.dmem_rr_valid = 0; req_fire = 0; rsp_fire = 0; wcnt = 0;
      end else begin
        if (rsp_fire) mif.dmem_rr_valid = 0;
        if (req_fire && !r_hold) begin mif.dmem_rr_valid = 1; mif.dmem_rr_data = r_data; end
        if (mif.dmem_r_valid) begin
          if (mif.dmem_r_addr !== r_exp_addr) r_bad_addr++;
          mif.dmem_r_ready = (wcnt >= r_delay);
          wcnt++;
        end else begin
          mif.dmem_r_ready = 0; wcnt = 0;
        end
        req_fire = mif.dmem_r_valid && mif.dmem_r_ready;
        if (req_fire) begin r_req_cnt++; wcnt = 0; end
        rsp_fire = mif.dmem_rr_valid && mif.dmem_rr_ready;
        if (rsp_fire) r_rsp_cnt++;
      end
    end
  end

  // data write responder
  initial begin : dmem_w_resp
    int wcnt;
    logic req_fire, rsp_fire;
    wcnt = 0; req_fire = 0; rsp_fire = 0;
    mif.dmem_w_ready = 0; mif.dmem_wr_valid = 0;
    forever begin
      @(negedge clk); #1;
      if (rst) begin
        mif.dmem_w_ready = 0; mif.dmem_wr_valid = 0; req_fire = 0; rsp_fire = 0; wcnt = 0;
      end else begin
        if (rsp_fire) mif.dmem_wr_valid = 0;
        if (req_fire) mif.dmem_wr_valid = 1;
        if (mif.dmem_w_valid) begin
          if (!w_seen) begin w_seen = 1; w_first_rrsp = r_rsp_cnt; end
          mif.dmem_w_ready = (wcnt >= w_delay);
          wcnt++;
        end else begin
          mif.dmem_w_ready = 0; wcnt = 0;
        end
        req_fire = mif.dmem_w_valid && mif.dmem_w_ready;
        if (req_fire) begin
          w_req_cnt++; wcnt = 0;
          w_last_addr = mif.dmem_w_addr; w_last_data = mif.dmem_w_data; w_last_mask = mif.dmem_w_mask;
        end
        rsp_fire = mif.dmem_wr_valid && mif.dmem_wr_ready;
      end
    end
  end

  // driver tasks: called on a falling edge in a CHK cycle; count cycles up to and including DONE
  task automatic drive(input logic [63:0] p, input logic re, input logic we, input logic [63:0] a,
                       input logic [63:0] wd, input logic [7:0] wm, input logic fi);
    pc = p; re_mem = re; we_mem = we; mem_addr = a; wdata = wd; wmask = wm; fence_i = fi;
  endtask

  task automatic run_inst(input logic [63:0] p, input logic re, input logic we, input logic [63:0] a,
                          input logic [63:0] wd, input logic [7:0] wm, input logic fi, output int cyc);
    drive(p, re, we, a, wd, wm, fi);
    #2;
    cyc = 1;
    while (stall && cyc < 100) begin
      @(negedge clk); #2;
      cyc++;
    end
    if (stall) check_eq("done_budget", 64'(stall), 64'd0);
    @(negedge clk);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int cyc;
    int base_i, base_v;
    bit reached;
    repeat (3) @(negedge clk);
    #2;
    check_eq("rst_stall", 64'(stall), 64'd1);
    check_eq("rst_ireq_valid", 64'(mif.imem_req_valid), 64'd0);
    check_eq("rst_inst_word", inst_word, 64'd0);
    check_eq("rst_rdata", rdata, 64'd0);
    check_eq("rst_bus_err", 64'(bus_err), 64'd0);
    check_eq("rst_state", 64'(dbg_state), 64'd0);

    // miss then buffer hit, zero-wait memory
    @(negedge clk);
    rst = 0;
    i_data = W0;
    run_inst(64'h0, 0, 0, 64'h0, 64'h0, 8'h00, 0, cyc);
    check_eq("miss_latency", 64'(cyc), 64'd4);
    check_eq("miss_inst_word", inst_word, W0);
    check_eq("miss_fetch_addr", i_last_addr, 64'h0);
    check_eq("miss_fetch_cnt", 64'(i_req_cnt), 64'd1);
    i_data = W1;
    run_inst(64'h4, 0, 0, 64'h0, 64'h0, 8'h00, 0, cyc);
    check_eq("hit_latency", 64'(cyc), 64'd2);
    check_eq("hit_no_fetch", 64'(i_req_cnt), 64'd1);
    check_eq("hit_inst_word", inst_word, W0);

    // load with a 3-cycle ready delay (just inside the timeout)
    r_delay = 3; r_data = R1; r_exp_addr = 64'h100;
    run_inst(64'h8, 1, 0, 64'h100, 64'h0, 8'h00, 0, cyc);
    check_eq("load_latency", 64'(cyc), 64'd9);
    check_eq("load_rdata", rdata, R1);
    check_eq("load_r_hs", 64'(r_req_cnt), 64'd1);
    check_eq("load_addr_stable", 64'(r_bad_addr), 64'd0);
    check_eq("load_inst_word", inst_word, W1);
    check_eq("load_fetch_addr", i_last_addr, 64'h8);
    check_eq("load_bus_err", 64'(bus_err), 64'd0);

    // combined read-then-write on a buffer hit
    r_delay = 0; r_data = R2; r_exp_addr = 64'h40; w_seen = 0;
    run_inst(64'hC, 1, 1, 64'h40, 64'hAAAA_BBBB_CCCC_DDDD, 8'h0F, 0, cyc);
    check_eq("rw_latency", 64'(cyc), 64'd6);
    check_eq("rw_read_before_write", 64'(w_first_rrsp), 64'd2);
    check_eq("rw_rdata", rdata, R2);
    check_eq("rw_w_addr", w_last_addr, 64'h40);
    check_eq("rw_w_mask", 64'(w_last_mask), 64'h0F);
    check_eq("rw_w_data", w_last_data, 64'hAAAA_BBBB_CCCC_DDDD);
    check_eq("rw_w_hs", 64'(w_req_cnt), 64'd1);
    run_inst(64'h8, 0, 0, 64'h0, 64'h0, 8'h00, 0, cyc);
    check_eq("unrelated_store_keeps_buf", 64'(cyc), 64'd2);

    // store into the buffered word invalidates it
    i_data = W0;
    run_inst(64'h0, 0, 1, 64'h0, 64'h1234, 8'hFF, 0, cyc);
    check_eq("smc_store_latency", 64'(cyc), 64'd6);
    run_inst(64'h4, 0, 0, 64'h0, 64'h0, 8'h00, 0, cyc);
    check_eq("smc_refetch_latency", 64'(cyc), 64'd4);
    check_eq("smc_refetch_cnt", 64'(i_req_cnt), 64'd4);

    // fence_i forces a refetch
    run_inst(64'h4, 0, 0, 64'h0, 64'h0, 8'h00, 1, cyc);
    check_eq("fence_latency", 64'(cyc), 64'd4);
    run_inst(64'h4, 0, 0, 64'h0, 64'h0, 8'h00, 0, cyc);
    check_eq("post_fence_hit", 64'(cyc), 64'd2);

    // fetch timeout: request ignored, valid held 4 cycles then abort via DONE
    i_delay = 1000; base_i = i_req_cnt; base_v = i_vcyc;
    run_inst(64'h10, 0, 0, 64'h0, 64'h0, 8'h00, 0, cyc);
    check_eq("to_latency", 64'(cyc), 64'd7);
    check_eq("to_bus_err", 64'(bus_err), 64'd1);
    check_eq("to_inst_word", inst_word, 64'd0);
    check_eq("to_valid_cycles", 64'(i_vcyc - base_v), 64'd4);
    check_eq("to_no_hs", 64'(i_req_cnt - base_i), 64'd0);
    i_delay = 0; i_data = W2;
    run_inst(64'h10, 0, 0, 64'h0, 64'h0, 8'h00, 0, cyc);
    check_eq("to_no_buf_fill", 64'(cyc), 64'd4);
    check_eq("to_bus_err_sticky", 64'(bus_err), 64'd1);
    check_eq("to_refetch_word", inst_word, W2);

    // reset asserted while waiting for a read reply
    r_hold = 1; r_exp_addr = 64'h200;
    drive(64'h14, 1, 0, 64'h200, 64'h0, 8'h00, 0);
    reached = 0;
    for (int k = 0; k < 20 && !reached; k++) begin
      @(negedge clk);
      if (dbg_state == 3'd4) reached = 1;
    end
    check_eq("reach_rd_wait", 64'(reached), 64'd1);
    rst = 1;
    #2;
    check_eq("rst_mid_valids",
             64'({mif.imem_req_valid, mif.imem_rsp_ready, mif.dmem_r_valid,
                  mif.dmem_rr_ready, mif.dmem_w_valid, mif.dmem_wr_ready}), 64'd0);
    check_eq("rst_mid_stall", 64'(stall), 64'd1);
    repeat (2) @(negedge clk);
    #2;
    check_eq("rst_mid_state", 64'(dbg_state), 64'd0);
    check_eq("rst_mid_bus_err", 64'(bus_err), 64'd0);
    check_eq("rst_mid_rdata", rdata, 64'd0);
    @(negedge clk);
    r_hold = 0; rst = 0; base_i = i_req_cnt;
    run_inst(64'h14, 0, 0, 64'h0, 64'h0, 8'h00, 0, cyc);
    check_eq("post_rst_miss", 64'(cyc), 64'd4);
    check_eq("post_rst_fetch", 64'(i_req_cnt - base_i), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_access_fsm.md
Name: mem_access_fsm

Overview:
- Multi-cycle memory sequencer between the core datapath and the instruction/data memory channels; replaces always-valid single-cycle memory access.
- Per instruction: fetches the 64-bit instruction word, then optionally performs a data read and/or write using valid/ready handshakes.
- Holds `stall` high until the instruction's memory work completes.
- Adds a one-entry instruction-word buffer (two instructions per word), a per-phase timeout, and a read-then-write sequence for combined accesses.

Parameters:
ADDR_W, 64, address width
DATA_W, 64, data/instruction-word width; power of two ≥32
MASK_W, DATA_W/8, byte write-mask width
IBUF_EN, 1, 1 = enable instruction-word buffer; 0 = fetch every instruction
TIMEOUT, 255, max cycles spent in one REQ or WAIT state before abort; 0 = no timeout

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
pc  in  ADDR_W  PC of current instruction; stable while stall=1
re_mem  in  1  current instruction reads data memory
we_mem  in  1  current instruction writes data memory
mem_addr  in  ADDR_W  data address (ALU result)
wdata  in  DATA_W  write data, pre-aligned
wmask  in  MASK_W  byte write mask
fence_i  in  1  invalidate instruction buffer (sampled in CHK)
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  fetch request accepted
imem_req_addr  out  ADDR_W  {pc[ADDR_W-1:3],3'b0}
imem_rsp_valid  in  1  fetch reply valid
imem_rsp_ready  out  1  fetch reply accepted
imem_rsp_data  in  DATA_W  fetched word
dmem_r_valid / dmem_r_ready / dmem_r_addr  out/in/out  1/1/ADDR_W  data read request channel
dmem_rr_valid / dmem_rr_ready / dmem_rr_data  in/out/in  1/1/DATA_W  data read reply channel
dmem_w_valid / dmem_w_ready  out/in  1/1  write request handshake
dmem_w_addr / dmem_w_data / dmem_w_mask  out  ADDR_W/DATA_W/MASK_W  write request payload
dmem_wr_valid / dmem_wr_ready  in/out  1/1  write completion channel
inst_word  out  DATA_W  registered fetched word; core selects half by pc[2]
rdata  out  DATA_W  registered data read result
stall  out  1  1 = core must hold PC and suppress register/memory commit
bus_err  out  1  sticky timeout flag

Behaviour:
- States: CHK, IF_REQ, IF_WAIT, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, DONE. State and all registers update only on clk.
- Reset:
  - While rst=1, force all *_valid/*_ready outputs to 0 and `stall` to 1.
  - At the reset edge: state←CHK, buffer invalid, inst_word=0, rdata=0, bus_err=0, timeout counter=0.
  - Reset mid-transaction abandons the transaction; no reply is awaited afterwards.
- `stall` = 1 in every state except DONE. DONE lasts exactly one cycle, during which the core commits and the PC advances. DONE → CHK.
- CHK:
  - Hit when IBUF_EN=1, buffer valid, fence_i=0, and pc[ADDR_W-1:3] equals the tag.
  - Hit: go to RD_REQ if re_mem, else WR_REQ if we_mem, else DONE.
  - Miss: go to IF_REQ.
  - fence_i=1 clears buffer valid.
- IF_REQ: imem_req_valid=1 with a stable address until imem_req_ready; then → IF_WAIT.
- IF_WAIT:
  - imem_rsp_ready=1.
  - On imem_rsp_valid: latch inst_word, set buffer tag and valid, then apply the same next-state choice as a CHK hit.
- RD_REQ/RD_WAIT: same handshake pattern on the dmem read channels. On reply, latch rdata; then → WR_REQ if we_mem, else DONE.
- WR_REQ/WR_WAIT: write request held until ready; the completion reply is accepted in WR_WAIT; then → DONE.
  - If mem_addr[ADDR_W-1:3] equals the buffer tag, clear buffer valid on write acceptance (self-modifying code).
- re_mem=we_mem=1: read fully completes before the write request is raised.
- Request-side valid never drops before its ready arrives. Reply-side ready is asserted only in the matching WAIT state.
- Timeout:
  - Counter clears on every state change and increments each cycle in a REQ/WAIT state.
  - When TIMEOUT≠0 and the counter = TIMEOUT: set bus_err, drop the current valid, and go to DONE.
  - On abort, latch 0 into the pending inst_word or rdata and do not mark the buffer valid.
- Latency with zero-wait memory (ready=1, reply one cycle after accept):
  - Miss, no data access: 4 cycles.
  - Buffer hit, no data access: 2 cycles.
  - Each data phase adds 2 cycles.

Test Plan:
- Zero-wait memory, pc=0x0 then 0x4, no data access → first instruction stalls 3 cycles (CHK, IF_REQ, IF_WAIT), DONE; second instruction hits the buffer with no imem request; inst_word unchanged.
- pc=0x8, load mem_addr=0x100, memory returns 0xDEADBEEF_CAFEF00D after a 3-cycle ready delay → dmem_r_addr stays 0x100 throughout; rdata=0xDEADBEEF_CAFEF00D at DONE; exactly one dmem_r handshake occurs.
- re_mem=we_mem=1, mem_addr=0x40, wmask=0x0F → read handshake completes before dmem_w_valid rises; one DONE pulse follows.
- Store to 0x0 while the buffer holds tag 0 → buffer invalidated; next pc=0x4 issues an imem request.
- TIMEOUT=4, imem_req_ready held at 0 → bus_err=1 after 4 cycles in IF_REQ; inst_word=0; state passes through DONE.
- rst asserted during RD_WAIT → all valids drop in the same cycle; after release the FSM starts at CHK with the buffer invalid.
